// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between client requesters and the shared-multiplier arbiter.
// The arbiter sits on the slave side; clients drive the master side.
interface mult_share_arbiter_if #(
    parameter int W    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_product;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier among NREQ requesters,
// returning each signed product tagged with the owning requester id.
module mult_share_arbiter #(
    parameter int W       = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus,
    output logic                 mul_start_o,
    output logic [W-1:0]         mul_a_o,
    output logic [W-1:0]         mul_b_o,
    input  logic [2*W-1:0]       mul_product_i,
    input  logic                 mul_done_i,
    output logic                 busy_o,
    output logic                 timeout_err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q, id_q, resp_id_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    mul_a_q, mul_b_q;
    logic [2*W-1:0]  resp_product_q;
    logic            mul_start_q, resp_valid_q, busy_q, timeout_err_q;

    logic [NREQ-1:0] hi_d, grant_oh_d;
    logic [W-1:0]    sel_a_d, sel_b_d;
    logic [IDW-1:0]  grant_id_d, rr_next_d;
    logic            grant_any_d;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
    assign hi_d        = bus.req_valid & ({NREQ{1'b1}} << rr_ptr_q);
    assign grant_oh_d  = (|hi_d) ? (hi_d & (~hi_d + NREQ'(1)))
                                 : (bus.req_valid & (~bus.req_valid + NREQ'(1)));
    assign grant_any_d = |bus.req_valid;

    // One-hot grant folded into id and operand selects without variable indexing.
    for (genvar i = 0; i < NREQ; i++) begin : g_sel
        logic [W-1:0]   a_cum, b_cum;
        logic [IDW-1:0] id_cum;
        if (i == 0) begin : g_first
            assign a_cum  = {W{grant_oh_d[0]}} & bus.req_a[0 +: W];
            assign b_cum  = {W{grant_oh_d[0]}} & bus.req_b[0 +: W];
            assign id_cum = '0;
        end else begin : g_next
            assign a_cum  = g_sel[i-1].a_cum | ({W{grant_oh_d[i]}} & bus.req_a[i*W +: W]);
            assign b_cum  = g_sel[i-1].b_cum | ({W{grant_oh_d[i]}} & bus.req_b[i*W +: W]);
            assign id_cum = g_sel[i-1].id_cum | (grant_oh_d[i] ? IDW'(i) : '0);
        end
    end

    assign sel_a_d    = g_sel[NREQ-1].a_cum;
    assign sel_b_d    = g_sel[NREQ-1].b_cum;
    assign grant_id_d = g_sel[NREQ-1].id_cum;
    assign rr_next_d  = (grant_id_d == IDW'(NREQ - 1)) ? '0 : grant_id_d + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            resp_id_q      <= '0;
            cnt_q          <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            resp_product_q <= '0;
            mul_start_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            mul_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        mul_a_q     <= sel_a_d;
                        mul_b_q     <= sel_b_d;
                        id_q        <= grant_id_d;
                        rr_ptr_q    <= rr_next_d;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_SETTLE;
                // done may still be high from the previous job here, so it is not looked at
                S_SETTLE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done_i) begin
                        resp_product_q <= mul_product_i;
                        resp_id_q      <= id_q;
                        resp_valid_q   <= 1'b1;
                        state_q        <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE && !rst) ? grant_oh_d : '0;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign mul_start_o      = mul_start_q;
    assign mul_a_o          = mul_a_q;
    assign mul_b_o          = mul_b_q;
    assign busy_o           = busy_q;
    assign timeout_err_o    = timeout_err_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: stub multiplier with programmable latency, per-requester
// op queues, and a cycle-level model of the grant/issue/wait/response sequence.
module tb_mult_share_arbiter;
    localparam int W = 32, NREQ = 4, IDW = 2, TIMEOUT = 255;

    logic clk, rst;
    logic mul_start, mul_done, busy, timeout_err;
    logic [W-1:0] mul_a, mul_b;
    logic [2*W-1:0] mul_product;

    mult_share_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_product_i(mul_product), .mul_done_i(mul_done),
        .busy_o(busy), .timeout_err_o(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub multiplier: done rises stub_lat edges after it samples start; hang suppresses done.
    int   stub_lat;
    logic stub_hang;
    int   stub_cnt;
    logic stub_run;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0; stub_run <= 1'b0; stub_cnt <= 0; mul_product <= '0;
        end else if (mul_start) begin
            stub_run    <= 1'b1; stub_cnt <= 0; mul_done <= 1'b0;
            mul_product <= longint'($signed(mul_a)) * longint'($signed(mul_b));
        end else if (stub_run) begin
            if (stub_cnt == stub_lat - 1) begin
                stub_run <= 1'b0;
                mul_done <= !stub_hang;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    endtask

    // Requester op queues; the driver pops on accept and presents the next op.
    int qa[NREQ][16], qb[NREQ][16];
    int qn[NREQ], qh[NREQ];
    logic [NREQ-1:0] acc_mask;

    task automatic push(input int r, input int a, input int b);
        qa[r][qn[r]] = a; qb[r][qn[r]] = b; qn[r]++;
    endtask

    initial begin
        logic [NREQ-1:0]   v;
        logic [NREQ*W-1:0] va, vb;
        forever begin
            @(posedge clk); #1;
            v = '0; va = '0; vb = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) qh[i]++;
                if (qh[i] < qn[i]) begin
                    v[i] = 1'b1; va[i*W +: W] = qa[i][qh[i]]; vb[i*W +: W] = qb[i][qh[i]];
                end
            end
            bus.req_valid = v; bus.req_a = va; bus.req_b = vb;
        end
    end

    // Behavioural model
    typedef struct { int id; int a; int b; } job_t;
    job_t exp_q[$];
    logic model_idle, got_done, to_due, idle_next;
    int   since_acc, rr, dut_to_cnt, last_resp_lat;
    int   log_id[32];
    longint log_p[32];
    int   log_n = 0;

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
        return '0;
    endfunction

    initial begin
        logic [NREQ-1:0] exp_ready;
        logic exp_to, exp_resp;
        job_t j;
        model_idle = 1; got_done = 0; to_due = 0; idle_next = 0;
        since_acc = 0; rr = 0; dut_to_cnt = 0; last_resp_lat = 0; acc_mask = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_idle = 1; got_done = 0; to_due = 0; idle_next = 0;
                since_acc = 0; rr = 0; exp_q.delete(); acc_mask = '0;
                chk("rst busy", 64'(busy), 0);
                chk("rst req_ready", 64'(bus.req_ready), 0);
                chk("rst resp_valid", 64'(bus.resp_valid), 0);
                chk("rst mul_start", 64'(mul_start), 0);
                chk("rst timeout_err", 64'(timeout_err), 0);
            end else begin
                if (timeout_err) dut_to_cnt++;
                if (idle_next) begin model_idle = 1; idle_next = 0; end
                exp_to = 0;
                if (to_due) begin
                    exp_to = 1; to_due = 0; model_idle = 1; void'(exp_q.pop_front());
                end
                if (!model_idle) since_acc++;
                exp_resp  = !model_idle && got_done;
                exp_ready = model_idle ? rr_pick(bus.req_valid, rr) : '0;

                chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
                chk("busy", 64'(busy), 64'(!model_idle));
                chk("timeout_err", 64'(timeout_err), 64'(exp_to));
                chk("mul_start", 64'(mul_start), 64'(!model_idle && since_acc == 1));
                chk("resp_valid", 64'(bus.resp_valid), 64'(exp_resp));
                if (!model_idle && exp_q.size() > 0) begin
                    chk("mul_a", {32'h0, mul_a}, {32'h0, 32'(exp_q[0].a)});
                    chk("mul_b", {32'h0, mul_b}, {32'h0, 32'(exp_q[0].b)});
                end
                if (exp_resp && exp_q.size() > 0) begin
                    chk("resp_id", 64'(bus.resp_id), 64'(exp_q[0].id));
                    chk("resp_product", bus.resp_product,
                        64'(longint'(exp_q[0].a) * longint'(exp_q[0].b)));
                    if (bus.resp_ready) begin
                        j = exp_q.pop_front();
                        log_id[log_n] = j.id;
                        log_p[log_n]  = longint'(j.a) * longint'(j.b);
                        log_n++;
                        idle_next = 1;
                    end
                end
                if (!model_idle && !got_done && since_acc >= 3) begin
                    if (mul_done) begin got_done = 1; last_resp_lat = since_acc + 1; end
                    else if (since_acc == 3 + TIMEOUT) to_due = 1;
                end
                acc_mask = bus.req_valid & bus.req_ready;
                if (model_idle && exp_ready != '0) begin
                    for (int i = 0; i < NREQ; i++) if (exp_ready[i]) begin
                        j.id = i; j.a = int'(bus.req_a[i*W +: W]); j.b = int'(bus.req_b[i*W +: W]);
                        rr = (i + 1) % NREQ;
                    end
                    exp_q.push_back(j);
                    model_idle = 0; since_acc = 0; got_done = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic wait_resps(input int n, input string name);
        int t = 0;
        while (log_n < n && t < 3000) begin @(posedge clk); t++; end
        chk(name, 64'(log_n), 64'(n));
    endtask

    initial begin
        int base;
        rst = 1'b1; stub_lat = 33; stub_hang = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin qn[i] = 0; qh[i] = 0; end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // 1: single request, full multiplier latency
        push(0, -3, 7);
        wait_resps(1, "t1 resp count");
        chk("t1 id", 64'(log_id[0]), 0);
        chk("t1 product", 64'(log_p[0]), -64'sd21);
        chk("t1 latency", 64'(last_resp_lat), 36);
        repeat (2) @(negedge clk);
        chk("t1 busy after", 64'(busy), 0);

        // 2: all four at once from rr_ptr=0
        do_reset();
        stub_lat = 3; base = log_n;
        for (int i = 0; i < NREQ; i++) push(i, i + 1, 10);
        wait_resps(base + 4, "t2 resp count");
        for (int i = 0; i < NREQ; i++) begin
            chk("t2 id order", 64'(log_id[base + i]), 64'(i));
            chk("t2 product", 64'(log_p[base + i]), 64'(10 * (i + 1)));
        end

        // 3: fairness between 0 and 2 held continuously
        do_reset();
        base = log_n;
        for (int k = 0; k < 3; k++) begin push(0, k + 1, 2); push(2, k + 1, 3); end
        wait_resps(base + 6, "t3 resp count");
        for (int k = 0; k < 6; k++)
            chk("t3 alternation", 64'(log_id[base + k]), 64'((k % 2) * 2));

        // 4: response back-pressure with req1 waiting
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        base = log_n;
        push(0, 5, 6);
        begin
            int t = 0;
            while (!bus.resp_valid && t < 200) begin @(negedge clk); t++; end
            chk("t4 resp_valid seen", 64'(bus.resp_valid), 1);
        end
        push(1, 7, 8);
        repeat (10) @(negedge clk);
        chk("t4 held ready", 64'(bus.req_ready), 0);
        chk("t4 held product", bus.resp_product, 64'sd30);
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4 req1 grant after handshake", 64'(bus.req_ready), 64'(4'b0010));
        wait_resps(base + 2, "t4 resp count");
        chk("t4 second product", 64'(log_p[base + 1]), 64'sd56);

        // 5: hung multiplier times out, then done exactly at the timeout count wins
        stub_hang = 1'b1; base = log_n;
        push(3, 1, 1);
        begin
            int t = 0;
            while (dut_to_cnt == 0 && t < 600) begin @(posedge clk); t++; end
        end
        repeat (3) @(negedge clk);
        chk("t5 timeout pulses", 64'(dut_to_cnt), 1);
        chk("t5 no response", 64'(log_n), 64'(base));
        chk("t5 idle after", 64'(busy), 0);
        stub_hang = 1'b0; stub_lat = TIMEOUT + 1;
        push(3, 4, 5);
        wait_resps(base + 1, "t5b resp count");
        chk("t5b done wins", 64'(dut_to_cnt), 1);
        chk("t5b product", 64'(log_p[base]), 64'sd20);

        // 6: reset while waiting on the multiplier
        stub_lat = 33; base = log_n;
        push(2, 9, 9);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6 busy", 64'(busy), 0);
        chk("t6 req_ready", 64'(bus.req_ready), 0);
        chk("t6 resp_valid", 64'(bus.resp_valid), 0);
        chk("t6 mul_start", 64'(mul_start), 0);
        chk("t6 mul_a", 64'(mul_a), 0);
        chk("t6 mul_b", 64'(mul_b), 0);
        chk("t6 resp_product", bus.resp_product, 0);
        chk("t6 timeout_err", 64'(timeout_err), 0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        push(0, 32'h7fffffff, -1);
        wait_resps(base + 1, "t6 resp count");
        chk("t6 id", 64'(log_id[base]), 0);
        chk("t6 product", 64'(log_p[base]), -64'sd2147483647);
        repeat (40) @(negedge clk);
        chk("t6 no stale response", 64'(log_n), 64'(base + 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
